// File: rtl/xillybus_regbank_pkg.sv
// Shared address map, CTRL bit positions and decode helpers for the
// xillybus mem_8 register bank.
package xillybus_regbank_pkg;

  localparam int ADDR_W = 5;

  localparam logic [ADDR_W-1:0] ADDR_SCRATCH_LAST = 5'd15;
  localparam logic [ADDR_W-1:0] ADDR_CYC0         = 5'd16;
  localparam logic [ADDR_W-1:0] ADDR_BCNT0        = 5'd20;
  localparam logic [ADDR_W-1:0] ADDR_CTRL         = 5'd24;
  localparam logic [ADDR_W-1:0] ADDR_STAT         = 5'd25;
  localparam logic [ADDR_W-1:0] ADDR_CFG0         = 5'd28;
  localparam logic [ADDR_W-1:0] ADDR_CFG3         = 5'd31;

  localparam int CTRL_CNT_RUN = 0;
  localparam int CTRL_CNT_CLR = 1;

  typedef enum logic [2:0] {
    REG_SCRATCH,
    REG_CYC,
    REG_BCNT,
    REG_CTRL,
    REG_STAT,
    REG_RSVD,
    REG_CFG
  } region_e;

  typedef enum logic {
    RD_SRC_REG,
    RD_SRC_RAM
  } rd_src_e;

  function automatic region_e decode_region(input logic [ADDR_W-1:0] addr);
    if (addr <= ADDR_SCRATCH_LAST)                   return REG_SCRATCH;
    else if (addr >= ADDR_CYC0 && addr < ADDR_BCNT0) return REG_CYC;
    else if (addr < ADDR_CTRL)                       return REG_BCNT;
    else if (addr == ADDR_CTRL)                      return REG_CTRL;
    else if (addr == ADDR_STAT)                      return REG_STAT;
    else if (addr < ADDR_CFG0)                       return REG_RSVD;
    else                                             return REG_CFG;
  endfunction

  // Little-endian byte lane of a 32-bit word.
  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] sel);
    logic [31:0] sh;
    sh = w >> {sel, 3'b000};
    return sh[7:0];
  endfunction

endpackage

// File: rtl/mem8_scratch_ram.sv
// 16x8 scratch RAM: one write port, one registered read port. A read and a
// write to the same word in one cycle return the old contents.
module mem8_scratch_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/xillybus_mem8_regbank.sv
// 32-byte seekable register bank behind the xillybus mem_8 stream: scratch
// RAM, snapshotted cycle counter, byte counter, CTRL/STAT and a staged config word.
module xillybus_mem8_regbank
  import xillybus_regbank_pkg::*;
#(
  parameter logic [31:0] CFG_RESET = 32'h0000_0000,
  parameter int          CNT_SAT   = 1
) (
  input  logic        bus_clk,
  input  logic        bus_rst,
  input  logic        quiesce,
  input  logic [4:0]  user_mem_8_addr,
  input  logic        user_mem_8_addr_update,
  input  logic        user_r_mem_8_rden,
  output logic [7:0]  user_r_mem_8_data,
  output logic        user_r_mem_8_empty,
  output logic        user_r_mem_8_eof,
  input  logic        user_r_mem_8_open,
  input  logic        user_w_mem_8_wren,
  input  logic [7:0]  user_w_mem_8_data,
  output logic        user_w_mem_8_full,
  input  logic        user_w_mem_8_open,
  output logic [31:0] cfg_word,
  output logic        cfg_update
);

  // The core tracks the address itself; the seek strobe carries no extra state.
  logic unused_addr_update;
  assign unused_addr_update = user_mem_8_addr_update;

  assign user_r_mem_8_empty = 1'b0;
  assign user_r_mem_8_eof   = 1'b0;
  assign user_w_mem_8_full  = 1'b0;

  function automatic logic [31:0] bcnt_next(input logic [31:0] v);
    if ((CNT_SAT != 0) && (&v)) return v;
    return v + 32'd1;
  endfunction

  region_e    region;
  logic [1:0] byte_sel;
  logic       rd_en;
  logic       wr_en;
  logic       ctrl_wr;
  logic       cnt_clr;
  logic       cfg_wr;

  logic [31:0] cyc_cnt;
  logic [23:0] cyc_snap;
  logic [31:0] bcnt;
  logic        cnt_run;
  logic [23:0] cfg_stage;
  logic        dirty;
  logic [3:0]  commit_cnt;
  logic [7:0]  stat;

  assign region   = decode_region(user_mem_8_addr);
  assign byte_sel = user_mem_8_addr[1:0];
  assign rd_en    = user_r_mem_8_rden;
  assign wr_en    = user_w_mem_8_wren;
  assign ctrl_wr  = wr_en && (region == REG_CTRL);
  assign cnt_clr  = ctrl_wr && user_w_mem_8_data[CTRL_CNT_CLR];
  assign cfg_wr   = wr_en && (region == REG_CFG);
  assign stat     = {commit_cnt, dirty, quiesce, user_w_mem_8_open, user_r_mem_8_open};

  logic [7:0] ram_q;

  mem8_scratch_ram #(
    .DATA_W (8),
    .ADDR_W (4)
  ) u_ram (
    .clk   (bus_clk),
    .we    (wr_en && (region == REG_SCRATCH)),
    .waddr (user_mem_8_addr[3:0]),
    .wdata (user_w_mem_8_data),
    .re    (rd_en && (region == REG_SCRATCH)),
    .raddr (user_mem_8_addr[3:0]),
    .rdata (ram_q)
  );

  // ---- stage p0: register read mux (byte 16 is live, 17-19 the snapshot)
  logic [7:0] rd_mux_p0;

  always_comb begin
    rd_mux_p0 = 8'h00;
    unique case (region)
      REG_CYC:  rd_mux_p0 = byte_of({cyc_snap, cyc_cnt[7:0]}, byte_sel);
      REG_BCNT: rd_mux_p0 = byte_of(bcnt, byte_sel);
      REG_CTRL: rd_mux_p0 = {6'b0, 1'b0, cnt_run};
      REG_STAT: rd_mux_p0 = stat;
      REG_CFG:  rd_mux_p0 = byte_of(cfg_word, byte_sel);
      default:  rd_mux_p0 = 8'h00;
    endcase
  end

  // ---- stage p1: registered read data, held until the next rden
  rd_src_e    rd_src_p1;
  logic [7:0] rd_reg_p1;

  always_ff @(posedge bus_clk) begin
    if (bus_rst) begin
      rd_src_p1 <= RD_SRC_REG;
      rd_reg_p1 <= 8'h00;
      cyc_snap  <= 24'h0;
    end else if (rd_en) begin
      rd_src_p1 <= (region == REG_SCRATCH) ? RD_SRC_RAM : RD_SRC_REG;
      rd_reg_p1 <= rd_mux_p0;
      if (region == REG_CYC && byte_sel == 2'd0) cyc_snap <= cyc_cnt[31:8];
    end
  end

  assign user_r_mem_8_data = (rd_src_p1 == RD_SRC_RAM) ? ram_q : rd_reg_p1;

  // A clear issued by the same write that would be counted takes priority.
  always_ff @(posedge bus_clk) begin
    if (bus_rst) begin
      cyc_cnt <= 32'h0;
      bcnt    <= 32'h0;
      cnt_run <= 1'b1;
    end else begin
      if (cnt_clr)      cyc_cnt <= 32'h0;
      else if (cnt_run) cyc_cnt <= cyc_cnt + 32'd1;

      if (cnt_clr)    bcnt <= 32'h0;
      else if (wr_en) bcnt <= bcnt_next(bcnt);

      if (ctrl_wr) cnt_run <= user_w_mem_8_data[CTRL_CNT_RUN];
    end
  end

  // Staging and commit: quiesce wipes partial staging and blocks commits.
  always_ff @(posedge bus_clk) begin
    if (bus_rst) begin
      cfg_stage  <= 24'h0;
      dirty      <= 1'b0;
      cfg_word   <= CFG_RESET;
      cfg_update <= 1'b0;
      commit_cnt <= 4'h0;
    end else begin
      cfg_update <= 1'b0;
      if (quiesce) begin
        cfg_stage <= 24'h0;
        dirty     <= 1'b0;
      end else if (cfg_wr) begin
        if (user_mem_8_addr == ADDR_CFG3) begin
          cfg_word   <= {user_w_mem_8_data, cfg_stage};
          cfg_update <= 1'b1;
          dirty      <= 1'b0;
          commit_cnt <= commit_cnt + 4'd1;
        end else begin
          unique case (byte_sel)
            2'd0:    cfg_stage[7:0]   <= user_w_mem_8_data;
            2'd1:    cfg_stage[15:8]  <= user_w_mem_8_data;
            default: cfg_stage[23:16] <= user_w_mem_8_data;
          endcase
          dirty <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_xillybus_mem8_regbank.sv
// Directed bench for xillybus_mem8_regbank: scratch RAM, counters, snapshot,
// config staging/commit, quiesce and reset behaviour.
module tb_xillybus_mem8_regbank;

  localparam logic [31:0] CFG_RST = 32'hCAFE_0001;

  logic        bus_clk = 1'b0;
  logic        bus_rst;
  logic        quiesce;
  logic [4:0]  user_mem_8_addr;
  logic        user_mem_8_addr_update;
  logic        user_r_mem_8_rden;
  logic [7:0]  user_r_mem_8_data;
  logic        user_r_mem_8_empty;
  logic        user_r_mem_8_eof;
  logic        user_r_mem_8_open;
  logic        user_w_mem_8_wren;
  logic [7:0]  user_w_mem_8_data;
  logic        user_w_mem_8_full;
  logic        user_w_mem_8_open;
  logic [31:0] cfg_word;
  logic        cfg_update;

  int n_checks = 0;
  int n_pass   = 0;
  int pulse_cnt = 0;

  xillybus_mem8_regbank #(
    .CFG_RESET (CFG_RST),
    .CNT_SAT   (1)
  ) dut (
    .bus_clk                (bus_clk),
    .bus_rst                (bus_rst),
    .quiesce                (quiesce),
    .user_mem_8_addr        (user_mem_8_addr),
    .user_mem_8_addr_update (user_mem_8_addr_update),
    .user_r_mem_8_rden      (user_r_mem_8_rden),
    .user_r_mem_8_data      (user_r_mem_8_data),
    .user_r_mem_8_empty     (user_r_mem_8_empty),
    .user_r_mem_8_eof       (user_r_mem_8_eof),
    .user_r_mem_8_open      (user_r_mem_8_open),
    .user_w_mem_8_wren      (user_w_mem_8_wren),
    .user_w_mem_8_data      (user_w_mem_8_data),
    .user_w_mem_8_full      (user_w_mem_8_full),
    .user_w_mem_8_open      (user_w_mem_8_open),
    .cfg_word               (cfg_word),
    .cfg_update             (cfg_update)
  );

  always #5 bus_clk = ~bus_clk;

  always @(posedge bus_clk) if (cfg_update === 1'b1) pulse_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Called at a negedge; returns at the negedge after the sampling edge.
  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    user_mem_8_addr   = a;
    user_w_mem_8_data = d;
    user_w_mem_8_wren = 1'b1;
    @(negedge bus_clk);
    user_w_mem_8_wren = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [4:0] a, input logic [7:0] exp);
    user_mem_8_addr   = a;
    user_r_mem_8_rden = 1'b1;
    @(negedge bus_clk);
    user_r_mem_8_rden = 1'b0;
    chk(tag, {24'h0, user_r_mem_8_data}, {24'h0, exp});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus_rst = 1'b1;
    quiesce = 1'b0;
    user_mem_8_addr = 5'd0;
    user_mem_8_addr_update = 1'b0;
    user_r_mem_8_rden = 1'b0;
    user_r_mem_8_open = 1'b1;
    user_w_mem_8_wren = 1'b0;
    user_w_mem_8_data = 8'h00;
    user_w_mem_8_open = 1'b1;
    repeat (3) @(negedge bus_clk);
    bus_rst = 1'b0;

    chk("rst_rdata", {24'h0, user_r_mem_8_data}, 32'h0);
    chk("rst_cfg_word", cfg_word, CFG_RST);
    chk("rst_cfg_update", {31'h0, cfg_update}, 32'h0);
    chk("tied_zero", {29'h0, user_r_mem_8_empty, user_r_mem_8_eof, user_w_mem_8_full}, 32'h0);
    rd("rst_ctrl", 5'd24, 8'h01);
    rd("rst_stat", 5'd25, 8'h03);
    rd("rst_bcnt", 5'd20, 8'h00);
    rd("rst_snap", 5'd17, 8'h00);

    // Scratch round-trip
    wr(5'd3, 8'hA5);
    wr(5'd15, 8'h5A);
    rd("ram_3", 5'd3, 8'hA5);
    rd("ram_15", 5'd15, 8'h5A);
    @(negedge bus_clk);
    chk("ram_hold", {24'h0, user_r_mem_8_data}, 32'h5A);
    rd("bcnt_two", 5'd20, 8'h02);

    // Same-cycle read/write collision
    wr(5'd5, 8'h01);
    user_mem_8_addr   = 5'd5;
    user_w_mem_8_data = 8'h02;
    user_w_mem_8_wren = 1'b1;
    user_r_mem_8_rden = 1'b1;
    @(negedge bus_clk);
    user_w_mem_8_wren = 1'b0;
    user_r_mem_8_rden = 1'b0;
    chk("collide_old", {24'h0, user_r_mem_8_data}, 32'h01);
    rd("collide_new", 5'd5, 8'h02);

    // Clear counters, then read 16 exactly when the cycle counter is 0xFF
    wr(5'd24, 8'h03);
    repeat (255) @(negedge bus_clk);
    rd("cyc_live_ff", 5'd16, 8'hFF);
    repeat (10) @(negedge bus_clk);
    rd("cyc_snap_17", 5'd17, 8'h00);
    rd("bcnt_cleared", 5'd20, 8'h00);
    rd("ctrl_after_clr", 5'd24, 8'h01);

    // Writes to read-only and reserved addresses are ignored but counted
    wr(5'd17, 8'h77);
    wr(5'd26, 8'h55);
    rd("ro_17", 5'd17, 8'h00);
    rd("rsvd_26", 5'd26, 8'h00);
    rd("bcnt_ro_writes", 5'd20, 8'h02);

    // Stopped counter stays at zero; restart counts from there
    wr(5'd24, 8'h02);
    repeat (5) @(negedge bus_clk);
    rd("cyc_stopped", 5'd16, 8'h00);
    rd("ctrl_stopped", 5'd24, 8'h00);
    wr(5'd24, 8'h01);
    repeat (3) @(negedge bus_clk);
    rd("cyc_restart", 5'd16, 8'h03);

    // Config staging and commit
    rd("cfg_rd_reset", 5'd28, 8'h01);
    wr(5'd28, 8'h11);
    chk("no_pulse_28", {31'h0, cfg_update}, 32'h0);
    wr(5'd29, 8'h22);
    wr(5'd30, 8'h33);
    rd("stat_dirty", 5'd25, 8'h0B);
    rd("cfg_rd_committed", 5'd28, 8'h01);
    chk("pulses_before", pulse_cnt, 32'd0);
    wr(5'd31, 8'h44);
    chk("cfg_commit", cfg_word, 32'h4433_2211);
    chk("pulse_high", {31'h0, cfg_update}, 32'h1);
    @(negedge bus_clk);
    chk("pulse_low", {31'h0, cfg_update}, 32'h0);
    chk("pulse_once", pulse_cnt, 32'd1);
    rd("stat_commit", 5'd25, 8'h13);
    rd("cfg_rd_31", 5'd31, 8'h44);
    rd("cfg_rd_29", 5'd29, 8'h22);

    // Quiesce abort
    wr(5'd28, 8'hEE);
    rd("stat_dirty2", 5'd25, 8'h1B);
    quiesce = 1'b1;
    @(negedge bus_clk);
    rd("stat_quiesce", 5'd25, 8'h17);
    wr(5'd31, 8'h99);
    chk("q_no_pulse", {31'h0, cfg_update}, 32'h0);
    @(negedge bus_clk);
    chk("q_pulses", pulse_cnt, 32'd1);
    chk("q_cfg_kept", cfg_word, 32'h4433_2211);
    quiesce = 1'b0;
    @(negedge bus_clk);
    rd("stat_after_q", 5'd25, 8'h13);

    // Reset in the middle of staging
    wr(5'd29, 8'hAB);
    bus_rst = 1'b1;
    @(negedge bus_clk);
    bus_rst = 1'b0;
    chk("mid_rst_cfg", cfg_word, CFG_RST);
    chk("mid_rst_rdata", {24'h0, user_r_mem_8_data}, 32'h0);
    chk("mid_rst_upd", {31'h0, cfg_update}, 32'h0);
    @(negedge bus_clk);
    chk("mid_rst_pulses", pulse_cnt, 32'd1);
    user_r_mem_8_open = 1'b0;
    user_w_mem_8_open = 1'b0;
    rd("mid_rst_stat", 5'd25, 8'h00);
    rd("mid_rst_ctrl", 5'd24, 8'h01);
    rd("mid_rst_bcnt", 5'd20, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
